// File: rtl/ps2_mouse_packet_rx_pkg.sv
// Shared PS/2 frame constants, FSM encodings and StatusByte bit positions
// for the mouse packet receiver.
package ps2_mouse_packet_rx_pkg;
    localparam int   FRAME_BITS = 11;
    localparam int   DATA_BITS  = FRAME_BITS - 3;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    localparam int YOVF  = 7;
    localparam int XOVF  = 6;
    localparam int YSIGN = 5;
    localparam int XSIGN = 4;
    localparam int ALIGN = 3;

    typedef enum logic [1:0] {BIT_IDLE, BIT_DATA, BIT_PARITY, BIT_STOP} bit_state_t;
    typedef enum logic [1:0] {B0, B1, B2} byte_state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
endpackage

// File: rtl/ps2_mouse_packet_rx_if.sv
// PS/2 line inputs and packet outputs of the mouse receiver.
interface ps2_mouse_packet_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] StatusByte;
    logic [7:0] XByte;
    logic [7:0] YByte;
    logic       trig_en;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data,
                    input  StatusByte, XByte, YByte, trig_en, frame_err);
    modport slave  (input  ps2_clk, ps2_data,
                    output StatusByte, XByte, YByte, trig_en, frame_err);
endinterface

// File: rtl/ps2_mouse_packet_rx_frame_rx.sv
// Line synchroniser, ps2_clk glitch filter, 11-bit frame deserialiser and
// inactivity timeout.
module ps2_frame_rx
    import ps2_mouse_packet_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       timeout
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, data_sync;
    logic [FW-1:0] flt_cnt;
    logic          filt, filt_d;
    logic          strobe;
    logic [TW-1:0] to_cnt;
    logic          active, to_hit;
    bit_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            flt_cnt   <= '0;
            filt      <= 1'b1;
            filt_d    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_d    <= filt;
            // Any sample agreeing with the filtered level restarts the run count.
            if (clk_sync[1] == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                filt    <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign strobe  = filt_d & ~filt;
    assign active  = (state != BIT_IDLE) || pkt_busy;
    assign to_hit  = active && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rx_byte = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BIT_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            timeout    <= 1'b0;
            if (strobe)
                to_cnt <= '0;
            else if (active && to_cnt != TW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + 1'b1;

            if (to_hit) begin
                state   <= BIT_IDLE;
                timeout <= 1'b1;
            end else if (strobe) begin
                case (state)
                    BIT_IDLE: if (data_sync[1] == START_BIT) begin
                        state   <= BIT_DATA;
                        bit_cnt <= '0;
                    end
                    BIT_DATA: begin
                        shreg   <= {data_sync[1], shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) state <= BIT_PARITY;
                    end
                    BIT_PARITY: begin
                        par   <= data_sync[1];
                        state <= BIT_STOP;
                    end
                    BIT_STOP: begin
                        if (data_sync[1] == STOP_BIT && odd_parity_ok(shreg, par))
                            byte_valid <= 1'b1;
                        else
                            byte_err <= 1'b1;
                        state <= BIT_IDLE;
                    end
                    default: state <= BIT_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver top: aligns received bytes into 3-byte movement packets
// and publishes them with a one-cycle trig_en.
module ps2_mouse_packet_rx
    import ps2_mouse_packet_rx_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic            clk,
    input logic            rst_n,
    ps2_mouse_packet_rx_if.slave bus
);
    byte_state_t bstate;
    logic [7:0]  rx_byte, stat_h, x_h;
    logic [7:0]  stat_q, x_q, y_q;
    logic        byte_valid, byte_err, timeout;
    logic        trig_q, ferr_q;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .pkt_busy  (bstate != B0),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate <= B0;
            stat_h <= '0;
            x_h    <= '0;
            stat_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            trig_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            ferr_q <= byte_err | timeout;
            if (byte_err || timeout) begin
                bstate <= B0;
            end else if (byte_valid) begin
                case (bstate)
                    // Only a byte with the always-one bit set can start a packet.
                    B0: if (rx_byte[ALIGN]) begin
                        stat_h <= rx_byte;
                        bstate <= B1;
                    end
                    B1: begin
                        x_h    <= rx_byte;
                        bstate <= B2;
                    end
                    B2: begin
                        stat_q <= stat_h;
                        x_q    <= x_h;
                        y_q    <= rx_byte;
                        trig_q <= 1'b1;
                        bstate <= B0;
                    end
                    default: bstate <= B0;
                endcase
            end
        end
    end

    assign bus.StatusByte = stat_q;
    assign bus.XByte      = x_q;
    assign bus.YByte      = y_q;
    assign bus.trig_en    = trig_q;
    assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed plus randomized bench for ps2_mouse_packet_rx with a packet-level
// reference model of the byte alignment rules.
module tb_ps2_mouse_packet_rx;
    localparam int FL       = 8;
    localparam int TO       = 1000;
    localparam int HALF     = 20;
    localparam int GAP      = 60;
    localparam int LONG_GAP = 1500;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_mouse_packet_rx_if bus();
    ps2_mouse_packet_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0, errors = 0;
    int cyc = 0, last_strobe = 0, trig_cnt = 0, ferr_cnt = 0, lat_bad = 0, chg_bad = 0;
    logic [7:0] prev_s = 8'h00, prev_x = 8'h00, prev_y = 8'h00;

    // Observes pulses, trig latency from the sampling strobe, and output stability.
    always @(negedge clk) begin
        cyc++;
        if (dut.u_frame.strobe === 1'b1) last_strobe = cyc;
        if (bus.trig_en === 1'b1) begin
            trig_cnt++;
            if (cyc - last_strobe != 2) lat_bad++;
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (rst_n === 1'b1 && bus.trig_en !== 1'b1 &&
            {bus.StatusByte, bus.XByte, bus.YByte} !== {prev_s, prev_x, prev_y})
            chg_bad++;
        prev_s = bus.StatusByte;
        prev_x = bus.XByte;
        prev_y = bus.YByte;
    end

    // Reference model: packet alignment expressed directly on received bytes.
    int         m_idx = 0;
    logic [7:0] m_hold [3];
    int         exp_trig = 0, exp_ferr = 0;
    logic [7:0] exp_s = 8'h00, exp_x = 8'h00, exp_y = 8'h00;

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_idx = 0;
            exp_ferr++;
        end else if (!(m_idx == 0 && b[3] == 1'b0)) begin
            m_hold[m_idx] = b;
            m_idx++;
            if (m_idx == 3) begin
                exp_trig++;
                exp_s = m_hold[0];
                exp_x = m_hold[1];
                exp_y = m_hold[2];
                m_idx = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic v, input bit glitch);
        bus.ps2_data = v;
        repeat (7) @(negedge clk);
        if (glitch) bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF - 10) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
        if (nbits == 11) model_byte(b, !bad_par);
    endtask

    task automatic idle(input int n);
        bus.ps2_data = 1'b1;
        repeat (n) @(negedge clk);
        if (n > TO && m_idx != 0) begin
            exp_ferr++;
            m_idx = 0;
        end
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit glitch);
        send_byte(b0, 1'b0, glitch, 11); idle(GAP);
        send_byte(b1, 1'b0, glitch, 11); idle(GAP);
        send_byte(b2, 1'b0, glitch, 11); idle(GAP);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_trig_cnt"}, trig_cnt, exp_trig);
        chk({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        chk({tag, "_status"}, bus.StatusByte, exp_s);
        chk({tag, "_x"}, bus.XByte, exp_x);
        chk({tag, "_y"}, bus.YByte, exp_y);
        chk({tag, "_latency_bad"}, lat_bad, 0);
        chk({tag, "_unexpected_change"}, chg_bad, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        rst_n = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_status", bus.StatusByte, 8'h00);
        chk("rst_trig", bus.trig_en, 1'b0);
        chk("rst_ferr", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all("reset");

        send_pkt(8'h08, 8'h05, 8'hFB, 1'b0);
        check_all("basic");

        send_byte(8'h08, 1'b0, 1'b0, 11); idle(GAP);
        send_byte(8'h05, 1'b1, 1'b0, 11); idle(GAP);
        check_all("parity_err");
        send_pkt(8'h19, 8'h80, 8'h7F, 1'b0);
        check_all("after_parity");

        send_byte(8'hFA, 1'b0, 1'b0, 11); idle(LONG_GAP);
        check_all("timeout");
        send_pkt(8'h28, 8'h10, 8'h20, 1'b0);
        check_all("after_timeout");

        send_byte(8'h00, 1'b0, 1'b0, 11); idle(GAP);
        send_pkt(8'h09, 8'hFF, 8'h01, 1'b0);
        check_all("resync");

        send_pkt(8'h0C, 8'h33, 8'h44, 1'b1);
        check_all("glitch");

        send_byte(8'h0B, 1'b0, 1'b0, 11); idle(GAP);
        send_byte(8'h55, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        m_idx = 0;
        exp_s = 8'h00; exp_x = 8'h00; exp_y = 8'h00;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_rst_status", bus.StatusByte, 8'h00);
        chk("in_rst_x", bus.XByte, 8'h00);
        chk("in_rst_y", bus.YByte, 8'h00);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_pkt(8'h0A, 8'h01, 8'h02, 1'b0);
        check_all("post_reset");

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                b   = 8'($urandom_range(0, 255));
                if (j == 0) b[3] = ($urandom_range(0, 7) != 0);
                bad = ($urandom_range(0, 7) == 0);
                send_byte(b, bad, 1'b0, 11);
                idle(GAP);
            end
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
